// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared execute-unit operation codes and result/CDB records
package cpu_types_pkg;
  localparam int XLEN_DEF = 32;
  localparam int PTAG_W_DEF = 6;
  localparam int ROB_W_DEF = 5;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_LUI  = 4'd10
  } alu_op_e;
  typedef struct packed {
    logic [PTAG_W_DEF-1:0] tag;
    logic [ROB_W_DEF-1:0]  rob;
    logic [XLEN_DEF-1:0]   data;
  } exec_result_t;
  typedef struct packed {
    logic                  valid;
    logic [PTAG_W_DEF-1:0] tag;
    logic [ROB_W_DEF-1:0]  rob;
    logic [XLEN_DEF-1:0]   data;
  } cdb_t;
endpackage

// File: rtl/exec_out_fifo.sv
// exec_out_fifo: synchronous result FIFO with flush, head presented combinationally
module exec_out_fifo
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter type entry_t = exec_result_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push_i,
  input  entry_t push_data_i,
  input  logic   pop_i,
  input  logic   flush_i,
  output logic   head_valid_o,
  output entry_t head_o
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  entry_t mem_q [DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic do_pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction
  assign head_valid_o = cnt_q != '0;
  assign head_o = mem_q[rp_q];
  assign do_pop = pop_i && head_valid_o;
  // Circular buffer; flush and reset only rewind pointers, stale data is never exposed
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wp_q] <= push_data_i;
        wp_q <= nxt(wp_q);
      end
      if (do_pop) rp_q <= nxt(rp_q);
      cnt_q <= cnt_q + CW'(push_i) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/alu_exec_pipe.sv
// alu_exec_pipe: RV32I ALU over LAT stages feeding a credit-gated CDB output queue
module alu_exec_pipe
  import cpu_types_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PTAG_W = 6,
  parameter int ROB_W = 5,
  parameter int LAT = 1,
  parameter int OUTQ_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid_i,
  output logic              issue_ready_o,
  input  logic [3:0]        alu_op_i,
  input  logic              use_imm_i,
  input  logic [XLEN-1:0]   rs1_data_i,
  input  logic [XLEN-1:0]   rs2_data_i,
  input  logic [XLEN-1:0]   imm_i,
  input  logic [PTAG_W-1:0] rd_phys_i,
  input  logic [ROB_W-1:0]  rob_idx_i,
  input  logic              flush_i,
  output logic              cdb_valid_o,
  input  logic              cdb_ready_i,
  output logic [PTAG_W-1:0] cdb_tag_o,
  output logic [ROB_W-1:0]  cdb_rob_o,
  output logic [XLEN-1:0]   cdb_data_o
);
  localparam int SHW = $clog2(XLEN);
  localparam int OW = $clog2(OUTQ_DEPTH + 1);
  typedef struct packed {
    logic [PTAG_W-1:0] tag;
    logic [ROB_W-1:0]  rob;
    logic [XLEN-1:0]   data;
  } res_t;
  logic [XLEN-1:0] op_b, alu_res;
  logic accept, pop, push, head_v;
  res_t s0_r, push_r, head_r;
  logic [OW-1:0] occ_q, occ_d;
  assign op_b = use_imm_i ? imm_i : rs2_data_i;
  // Stage-1 ALU; undefined encodings produce zero but still broadcast
  always_comb begin
    case (alu_op_e'(alu_op_i))
      ALU_ADD:  alu_res = rs1_data_i + op_b;
      ALU_SUB:  alu_res = rs1_data_i - op_b;
      ALU_AND:  alu_res = rs1_data_i & op_b;
      ALU_OR:   alu_res = rs1_data_i | op_b;
      ALU_XOR:  alu_res = rs1_data_i ^ op_b;
      ALU_SLL:  alu_res = rs1_data_i << op_b[SHW-1:0];
      ALU_SRL:  alu_res = rs1_data_i >> op_b[SHW-1:0];
      ALU_SRA:  alu_res = $unsigned($signed(rs1_data_i) >>> op_b[SHW-1:0]);
      ALU_SLT:  alu_res = XLEN'($signed(rs1_data_i) < $signed(op_b));
      ALU_SLTU: alu_res = XLEN'(rs1_data_i < op_b);
      ALU_LUI:  alu_res = imm_i;
      default:  alu_res = '0;
    endcase
  end
  assign pop = head_v && cdb_ready_i;
  assign issue_ready_o = !rst && (occ_q < OW'(OUTQ_DEPTH) || pop);
  assign accept = issue_valid_i && issue_ready_o;
  assign s0_r = {rd_phys_i, rob_idx_i, alu_res};
  assign occ_d = (rst || flush_i) ? '0 : occ_q + OW'(accept) - OW'(pop);
  // Credit counter: results in the pipeline plus results waiting in the queue
  always_ff @(posedge clk) occ_q <= occ_d;
  if (LAT == 1) begin : g_direct
    assign push = accept && !flush_i;
    assign push_r = s0_r;
  end else begin : g_pipe
    logic [LAT-2:0] v_q;
    res_t r_q [LAT-1];
    // Non-stalling result pipeline; credits guarantee the queue has room at the end
    always_ff @(posedge clk) begin
      v_q[0] <= accept && !flush_i && !rst;
      r_q[0] <= s0_r;
      for (int i = 1; i < LAT - 1; i++) begin
        v_q[i] <= v_q[i-1] && !flush_i && !rst;
        r_q[i] <= r_q[i-1];
      end
    end
    assign push = v_q[LAT-2];
    assign push_r = r_q[LAT-2];
  end
  exec_out_fifo #(.DEPTH(OUTQ_DEPTH), .entry_t(res_t)) u_outq (
    .clk(clk),
    .rst(rst),
    .push_i(push),
    .push_data_i(push_r),
    .pop_i(pop),
    .flush_i(flush_i),
    .head_valid_o(head_v),
    .head_o(head_r)
  );
  assign cdb_valid_o = head_v;
  assign cdb_tag_o = head_v ? head_r.tag : '0;
  assign cdb_rob_o = head_v ? head_r.rob : '0;
  assign cdb_data_o = head_v ? head_r.data : '0;
endmodule

// File: tb/tb_alu_exec_pipe.sv
// tb_alu_exec_pipe: scoreboard bench over three latency/depth configurations
module tb_alu_exec_pipe;
  typedef struct packed {
    logic [5:0]  tag;
    logic [4:0]  rob;
    logic [31:0] data;
  } exp_t;
  logic clk = 1'b0;
  logic rst, flush, ui;
  logic [3:0] op;
  logic [31:0] a, b, im;
  logic [5:0] tag;
  logic [4:0] rob;
  logic iv [3];
  logic cr [3];
  logic ir [3];
  logic cv [3];
  logic [5:0] ctag [3];
  logic [4:0] crob [3];
  logic [31:0] cdata [3];
  exp_t sb [3][$];
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    alu_exec_pipe #(.XLEN(32), .PTAG_W(6), .ROB_W(5), .LAT(g + 1), .OUTQ_DEPTH(g + 1)) u_dut (
      .clk(clk),
      .rst(rst),
      .issue_valid_i(iv[g]),
      .issue_ready_o(ir[g]),
      .alu_op_i(op),
      .use_imm_i(ui),
      .rs1_data_i(a),
      .rs2_data_i(b),
      .imm_i(im),
      .rd_phys_i(tag),
      .rob_idx_i(rob),
      .flush_i(flush),
      .cdb_valid_o(cv[g]),
      .cdb_ready_i(cr[g]),
      .cdb_tag_o(ctag[g]),
      .cdb_rob_o(crob[g]),
      .cdb_data_o(cdata[g])
    );
  end
  function automatic logic [31:0] model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] r;
    int sh;
    sh = int'(y[4:0]);
    r = x;
    case (o)
      4'd0: r = x + y;
      4'd1: r = x - y;
      4'd2: r = x & y;
      4'd3: r = x | y;
      4'd4: r = x ^ y;
      4'd5: repeat (sh) r = {r[30:0], 1'b0};
      4'd6: repeat (sh) r = {1'b0, r[31:1]};
      4'd7: repeat (sh) r = {r[31], r[31:1]};
      4'd8: r = (x[31] != y[31]) ? {31'b0, x[31]} : {31'b0, x < y};
      4'd9: r = {31'b0, x < y};
      default: r = 32'b0;
    endcase
    return r;
  endfunction
  // Scoreboard: pops are compared before same-cycle accepts, then flush/reset empties the queues
  always @(negedge clk) begin
    exp_t e;
    for (int g = 0; g < 3; g++) begin
      if (cv[g] === 1'b1 && cr[g] === 1'b1) begin
        n_chk++;
        if (sb[g].size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected dut%0d: got tag=%0d data=%h, required no result", g, ctag[g], cdata[g]);
        end else begin
          e = sb[g].pop_front();
          if ({ctag[g], crob[g], cdata[g]} !== {e.tag, e.rob, e.data}) begin
            n_fail++;
            $display("FAIL sb_result dut%0d: got tag=%0d rob=%0d data=%h, required tag=%0d rob=%0d data=%h",
                     g, ctag[g], crob[g], cdata[g], e.tag, e.rob, e.data);
          end
        end
      end
      if (iv[g] && ir[g] === 1'b1 && !flush && !rst) begin
        e.tag = tag;
        e.rob = rob;
        e.data = (op == 4'd10) ? im : model(op, a, ui ? im : b);
        sb[g].push_back(e);
      end
      if (flush || rst) sb[g].delete();
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input int g, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] i, input logic u, input logic [5:0] t, input logic [4:0] r);
    op = o; a = x; b = y; im = i; ui = u; tag = t; rob = r; iv[g] = 1'b1;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      n_chk++;
      if (ir[g] !== 1'b0 || cv[g] !== 1'b0 || {ctag[g], crob[g], cdata[g]} !== 43'b0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: got ready=%b valid=%b tag=%0d rob=%0d data=%h, required all 0",
                 g, ir[g], cv[g], ctag[g], crob[g], cdata[g]);
      end
    end
    tick;
    rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      n_chk++;
      if (ir[g] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_release_ready dut%0d: got %b, required 1", g, ir[g]);
      end
    end
  endtask
  task automatic test_back_to_back;
    tick;
    cr[0] = 1'b1;
    drive(0, 4'd0, 32'd5, 32'd7, 32'd0, 1'b0, 6'd3, 5'd1);
    @(negedge clk);
    n_chk++;
    if (ir[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_ready0: got %b, required 1", ir[0]); end
    tick;
    drive(0, 4'd1, 32'd5, 32'd7, 32'd0, 1'b0, 6'd4, 5'd2);
    @(negedge clk);
    n_chk++;
    if (ir[0] !== 1'b1 || cv[0] !== 1'b1 || cdata[0] !== 32'd12 || ctag[0] !== 6'd3) begin
      n_fail++;
      $display("FAIL b2b_first: got ready=%b valid=%b data=%h tag=%0d, required 1 1 0000000c 3", ir[0], cv[0], cdata[0], ctag[0]);
    end
    tick;
    iv[0] = 1'b0;
    @(negedge clk);
    n_chk++;
    if (cv[0] !== 1'b1 || cdata[0] !== 32'hFFFFFFFE || ctag[0] !== 6'd4) begin
      n_fail++;
      $display("FAIL b2b_second: got valid=%b data=%h tag=%0d, required 1 fffffffe 4", cv[0], cdata[0], ctag[0]);
    end
    tick;
    @(negedge clk);
    n_chk++;
    if (cv[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got valid=%b, required 0", cv[0]); end
  endtask
  task automatic test_imm_undef;
    tick;
    drive(0, 4'd10, 32'hDEADBEEF, 32'h1, 32'h12345000, 1'b1, 6'd5, 5'd6);
    @(negedge clk);
    tick;
    drive(0, 4'hF, 32'd5, 32'd7, 32'd0, 1'b0, 6'd9, 5'd7);
    @(negedge clk);
    n_chk++;
    if (cv[0] !== 1'b1 || cdata[0] !== 32'h12345000 || ctag[0] !== 6'd5) begin
      n_fail++;
      $display("FAIL lui: got valid=%b data=%h tag=%0d, required 1 12345000 5", cv[0], cdata[0], ctag[0]);
    end
    tick;
    iv[0] = 1'b0;
    @(negedge clk);
    n_chk++;
    if (cv[0] !== 1'b1 || cdata[0] !== 32'd0 || ctag[0] !== 6'd9) begin
      n_fail++;
      $display("FAIL undef_op: got valid=%b data=%h tag=%0d, required 1 00000000 9", cv[0], cdata[0], ctag[0]);
    end
  endtask
  task automatic test_latency;
    logic [3:0] ops [3] = '{4'd8, 4'd9, 4'd7};
    logic [31:0] xs [3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
    logic [31:0] ys [3] = '{32'd1, 32'd1, 32'h24};
    logic [31:0] ex [3] = '{32'd1, 32'd0, 32'hF8000000};
    int lat;
    logic [31:0] got;
    for (int t = 0; t < 3; t++) begin
      tick;
      cr[2] = 1'b1;
      drive(2, ops[t], xs[t], ys[t], 32'd0, 1'b0, 6'(20 + t), 5'(t));
      @(negedge clk);
      tick;
      iv[2] = 1'b0;
      lat = 0;
      got = 32'hx;
      for (int c = 1; c <= 8; c++) begin
        @(negedge clk);
        if (cv[2] === 1'b1 && lat == 0) begin lat = c; got = cdata[2]; end
      end
      n_chk++;
      if (lat != 3 || got !== ex[t]) begin
        n_fail++;
        $display("FAIL latency_op%0d: got latency=%0d data=%h, required latency=3 data=%h", ops[t], lat, got, ex[t]);
      end
    end
  endtask
  task automatic test_backpressure;
    logic [3:0] ops [4] = '{4'd0, 4'd4, 4'd3, 4'd2};
    logic [31:0] xs [4] = '{32'd1, 32'hF0, 32'h0F00, 32'hFF};
    logic [31:0] ys [4] = '{32'd1, 32'hFF, 32'h00F0, 32'h0F};
    int idx;
    logic acc;
    idx = 0;
    tick;
    cr[1] = 1'b0;
    drive(1, ops[0], xs[0], ys[0], 32'd0, 1'b0, 6'd10, 5'd10);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      acc = ir[1];
      tick;
      if (acc) begin
        idx++;
        drive(1, ops[idx], xs[idx], ys[idx], 32'd0, 1'b0, 6'(10 + idx), 5'(10 + idx));
      end
    end
    @(negedge clk);
    n_chk++;
    if (idx != 2 || ir[1] !== 1'b0 || cv[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_stall: got accepts=%0d ready=%b valid=%b, required 2 0 1", idx, ir[1], cv[1]);
    end
    tick;
    cr[1] = 1'b1;
    @(negedge clk);
    n_chk++;
    if (ir[1] !== 1'b1) begin n_fail++; $display("FAIL bp_pop_credit: got ready=%b, required 1", ir[1]); end
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      acc = iv[1] && ir[1];
      tick;
      if (acc) begin
        idx++;
        if (idx < 4) drive(1, ops[idx], xs[idx], ys[idx], 32'd0, 1'b0, 6'(10 + idx), 5'(10 + idx));
        else iv[1] = 1'b0;
      end
    end
    n_chk++;
    if (idx != 4 || sb[1].size() != 0) begin
      n_fail++;
      $display("FAIL bp_drain: got accepts=%0d pending=%0d, required 4 0", idx, sb[1].size());
    end
  endtask
  task automatic test_flush;
    logic any_v;
    tick;
    cr[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(2, 4'd0, 32'(i), 32'd100, 32'd0, 1'b0, 6'(30 + i), 5'(i));
      @(negedge clk);
      tick;
    end
    drive(2, 4'd0, 32'd3, 32'd100, 32'd0, 1'b0, 6'd33, 5'd3);
    flush = 1'b1;
    @(negedge clk);
    n_chk++;
    if (cv[2] !== 1'b1 || ctag[2] !== 6'd30 || cdata[2] !== 32'd100) begin
      n_fail++;
      $display("FAIL flush_cycle_head: got valid=%b tag=%0d data=%h, required 1 30 00000064", cv[2], ctag[2], cdata[2]);
    end
    tick;
    flush = 1'b0;
    iv[2] = 1'b0;
    any_v = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (cv[2] !== 1'b0) any_v = 1'b1;
    end
    n_chk++;
    if (any_v) begin n_fail++; $display("FAIL flush_kill: got valid after flush=1, required 0"); end
    tick;
    cr[2] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(2, 4'd1, 32'd50, 32'(i), 32'd0, 1'b0, 6'(40 + i), 5'(20 + i));
      @(negedge clk);
      n_chk++;
      if (ir[2] !== (i < 3)) begin
        n_fail++;
        $display("FAIL flush_occ_ready%0d: got %b, required %b", i, ir[2], i < 3);
      end
      tick;
    end
    iv[2] = 1'b0;
    cr[2] = 1'b1;
    repeat (8) @(negedge clk);
    n_chk++;
    if (sb[2].size() != 0) begin n_fail++; $display("FAIL flush_after_drain: got pending=%0d, required 0", sb[2].size()); end
  endtask
  task automatic test_rst_midop;
    tick;
    cr[1] = 1'b0;
    drive(1, 4'd0, 32'd1, 32'd2, 32'd0, 1'b0, 6'd50, 5'd1);
    @(negedge clk);
    tick;
    drive(1, 4'd0, 32'd3, 32'd4, 32'd0, 1'b0, 6'd51, 5'd2);
    @(negedge clk);
    tick;
    iv[1] = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (cv[1] !== 1'b1 || ir[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_full_setup: got valid=%b ready=%b, required 1 0", cv[1], ir[1]);
    end
    tick;
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if (ir[1] !== 1'b0) begin n_fail++; $display("FAIL rst_ready_low: got %b, required 0", ir[1]); end
    tick;
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (cv[1] !== 1'b0 || {ctag[1], crob[1], cdata[1]} !== 43'b0 || ir[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_midop: got valid=%b tag=%0d rob=%0d data=%h ready=%b, required 0 0 0 0 1",
               cv[1], ctag[1], crob[1], cdata[1], ir[1]);
    end
  endtask
  task automatic test_random;
    for (int c = 0; c < 400; c++) begin
      tick;
      cr[2] = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 59) == 0;
      if ($urandom_range(0, 3) != 0)
        drive(2, 4'($urandom_range(0, 15)), $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
              6'($urandom), 5'($urandom));
      else iv[2] = 1'b0;
    end
    tick;
    iv[2] = 1'b0;
    flush = 1'b0;
    cr[2] = 1'b1;
    repeat (10) @(negedge clk);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    rst = 1'b1; flush = 1'b0; ui = 1'b0; op = '0; a = '0; b = '0; im = '0; tag = '0; rob = '0;
    for (int g = 0; g < 3; g++) begin iv[g] = 1'b0; cr[g] = 1'b0; end
    test_reset;
    test_back_to_back;
    test_imm_undef;
    test_latency;
    test_backpressure;
    test_flush;
    test_rst_midop;
    test_random;
    for (int g = 0; g < 3; g++) begin
      n_chk++;
      if (sb[g].size() != 0) begin
        n_fail++;
        $display("FAIL final_drain dut%0d: got pending=%0d, required 0", g, sb[g].size());
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_exec_pipe.md
# alu_exec_pipe

Parametrised integer execute unit that sits between the ALU reservation station / PRF read stage and the CDB arbiter. It implements the full RV32I register/immediate ALU op set over a configurable number of pipeline stages, with a credit-gated output queue. The queue absorbs CDB backpressure, and a pipeline flush kills in-flight results. It replaces the fixed single-cycle, always-ready ALU.

## Interface
- XLEN, 32, operand/result width
- PTAG_W, 6, physical destination tag width
- ROB_W, 5, ROB index width
- LAT, 1, execute latency in cycles; legal range 1..4
- OUTQ_DEPTH, 2, output queue entries; must be ≥1; full throughput requires ≥ LAT

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- issue_valid_i  in  1  issue request
- issue_ready_o  out  1  unit can accept this cycle
- alu_op_i  in  4  alu_op_e operation
- use_imm_i  in  1  operand B = imm_i instead of rs2_data_i
- rs1_data_i  in  XLEN  operand A from PRF
- rs2_data_i  in  XLEN  operand B from PRF
- imm_i  in  XLEN  sign-extended immediate
- rd_phys_i  in  PTAG_W  destination physical tag
- rob_idx_i  in  ROB_W  ROB entry
- flush_i  in  1  kill all in-flight and queued results
- cdb_valid_o  out  1  result available
- cdb_ready_i  in  1  CDB arbiter grant
- cdb_tag_o  out  PTAG_W  physical tag of the result
- cdb_rob_o  out  ROB_W  ROB index of the result
- cdb_data_o  out  XLEN  result value

## Operation
- Accept occurs when issue_valid_i && issue_ready_o.
- Operand B = use_imm_i ? imm_i : rs2_data_i.
- Ops:
  - ADD, SUB, AND, OR, XOR: modulo 2^XLEN.
  - SLL, SRL, SRA: shift amount = B[$clog2(XLEN)-1:0].
  - SLT: signed compare. SLTU: unsigned compare. Both return 0 or 1, zero-extended.
  - LUI: result = imm_i.
  - Undefined encodings: result 0, still broadcast with their tag.
- The result is computed combinationally in stage 1, then travels through LAT-1 valid-tagged pipeline registers (tag, rob, data). It is written into the output queue on the LAT-th edge after accept.
- Pipeline registers never stall; admission is controlled by credits instead.
- occ = valid pipeline entries + queue entries; 0..OUTQ_DEPTH.
- issue_ready_o = !rst && (occ < OUTQ_DEPTH || (cdb_valid_o && cdb_ready_i)). This is a combinational path from cdb_ready_i; the credit freed by a same-cycle pop may be reused.
- Next occ = occ + accept − pop. It can never exceed OUTQ_DEPTH, so the queue never overflows.
- The queue head drives the cdb_* outputs. Pop occurs when cdb_valid_o && cdb_ready_i. Results leave in issue order.
- While cdb_valid_o is high, head contents are stable until popped.
- flush_i, at the edge it is sampled:
  - clears all pipeline valids, the queue and occ.
  - An accept in the same cycle is discarded.
  - A CDB transfer in the flush cycle is complete and valid; outputs are not masked.
  - cdb_valid_o is 0 from the next cycle.
- Reset, at the edge:
  - cdb_valid_o=0, cdb_tag_o=0, cdb_rob_o=0, cdb_data_o=0; occ=0; all valids cleared.
  - issue_ready_o=0 while rst is high, and 1 in the first cycle after.
- Reset asserted mid-operation drops everything in flight, identically to flush.

## Timing
- Latency: accept at edge k → cdb_valid_o high in the cycle after edge k+LAT−1. LAT=1 gives next-cycle broadcast, matching the previous unit.
- Throughput: 1 op/cycle sustained when cdb_ready_i is held high and OUTQ_DEPTH ≥ LAT.
- Backpressure: with cdb_ready_i low, at most OUTQ_DEPTH accepts occur before issue_ready_o drops. The first pop re-raises issue_ready_o combinationally in the same cycle.
- Empty queue with an arriving result: no bypass; the result is visible one cycle after its queue-write edge.

## Structure
- cpu_types_pkg holds shared definitions:
  - alu_op_e (4-bit): ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9, LUI=10.
  - exec_result_t {tag, rob, data}.
  - The cdb_t extension with a rob field.
- Sub-module exec_out_fifo: synchronous FIFO of exec_result_t, depth OUTQ_DEPTH, with push/pop/flush and head outputs.
- The ALU function is an always_comb block inside alu_exec_pipe.

## Test plan
- LAT=1, DEPTH=1, cdb_ready=1: issue ADD 5+7 tag 3, then SUB 5−7 tag 4 back-to-back → cdb shows 12/tag3, then 0xFFFFFFFE/tag4 on consecutive cycles; issue_ready never drops.
- LAT=3, DEPTH=3: SLT(0xFFFFFFFF,1) → 1 and SLTU(0xFFFFFFFF,1) → 0; SRA(0x80000000, B=0x24) → 0xF8000000 (shamt 4). Each result appears 3 cycles after accept.
- LAT=2, DEPTH=2, cdb_ready=0: issue 4 ops → only 2 accepted, issue_ready=0. Raise cdb_ready → results drain in order, and the 3rd op is accepted in the first pop cycle.
- LAT=3: accept 3 ops, assert flush on the cycle a 4th is offered → no cdb_valid afterwards, occ=0, and the next issue completes normally with tag intact.
- Assert rst with the queue full and cdb_ready=0 → next cycle all cdb outputs are 0, and issue_ready=1 the cycle after rst falls.
- use_imm: LUI imm=0x12345000 → 0x12345000; undefined op 4'hF with tag 9 → data 0, tag 9 broadcast.
